// File: rtl/maze_pkg.sv
// Shared definitions for the maze stage and its downstream wire-cut judge:
// judge FSM encodings, wire colour codes, default game tuning and saturating math.
package maze_pkg;

  typedef logic [2:0] judge_state_t;

  localparam judge_state_t ST_IDLE     = 3'd0;
  localparam judge_state_t ST_ARMED    = 3'd1;
  localparam judge_state_t ST_STRIKE   = 3'd2;
  localparam judge_state_t ST_DEFUSED  = 3'd3;
  localparam judge_state_t ST_EXPLODED = 3'd4;

  typedef logic [2:0] colour_t;

  // Colour 0 means "no wire targeted"; the maze drives it between targets.
  localparam colour_t COL_NONE   = 3'd0;
  localparam colour_t COL_RED    = 3'd1;
  localparam colour_t COL_GREEN  = 3'd2;
  localparam colour_t COL_BLUE   = 3'd3;
  localparam colour_t COL_YELLOW = 3'd4;
  localparam colour_t COL_WHITE  = 3'd5;
  localparam colour_t COL_BLACK  = 3'd6;
  localparam colour_t COL_ORANGE = 3'd7;

  localparam int DEF_START_SECS   = 90;
  localparam int DEF_PENALTY_SECS = 10;
  localparam int DEF_MAX_STRIKES  = 3;

  function automatic logic [7:0] sat_sub8(input logic [7:0] a, input logic [7:0] b);
    return (b >= a) ? 8'd0 : (a - b);
  endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// Enabled clock divider: one-cycle tick every TICK_DIV enabled cycles.
// Dropping en clears the count so the next enabled period starts from zero.
module sec_tick_gen #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt <= '0;
    end else if (!en) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/wire_cut_judge.sv
// Judge for the maze stage: countdown, strike/cut bookkeeping and the
// defused/exploded verdict, with every output registered for the display stages.
module wire_cut_judge
  import maze_pkg::*;
#(
  parameter int TICK_DIV      = 100_000_000,
  parameter int START_SECS    = DEF_START_SECS,
  parameter int PENALTY_SECS  = DEF_PENALTY_SECS,
  parameter int MAX_STRIKES   = DEF_MAX_STRIKES,
  parameter int WIRES_NEEDED  = 3,
  parameter int STRIKE_CYCLES = 8
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       start,
  input  logic [2:0] wire_to_cut,
  input  logic       cut_req,
  input  logic [2:0] cut_colour,
  output logic       pause,
  output logic [6:0] secs_left,
  output logic [1:0] strikes,
  output logic [1:0] wires_done,
  output logic [2:0] state_o,
  output logic       flash,
  output logic       defused,
  output logic       exploded
);

  localparam int SCW = (STRIKE_CYCLES > 1) ? $clog2(STRIKE_CYCLES) : 1;
  localparam logic [SCW-1:0] STRIKE_LAST = SCW'(STRIKE_CYCLES - 1);

  judge_state_t   state, next_state;
  logic [6:0]     secs_q, secs_d;
  logic [1:0]     strikes_q, strikes_d;
  logic [1:0]     wires_q, wires_d;
  logic [SCW-1:0] strike_cnt_q, strike_cnt_d;
  logic           pause_d, flash_d, defused_d, exploded_d;

  logic       live, tick, rearm;
  logic       cut_valid, cut_hit, cut_miss;
  logic       defuse_now, strike_out, secs_zero;
  logic [7:0] dec_amt;
  logic [6:0] secs_live_next;

  sec_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .CLK   (CLK),
    .RST_N (RST_N),
    .en    (live),
    .tick  (tick)
  );

  // cut_req is a single-cycle request with no back-pressure: it is acted on
  // only in ARMED with a wire targeted, and wire_to_cut/cut_colour are read
  // in that same cycle and never held.
  assign live      = (state == ST_ARMED) || (state == ST_STRIKE);
  assign rearm     = start && ((state == ST_IDLE) || (state == ST_DEFUSED) ||
                               (state == ST_EXPLODED));
  assign cut_valid = (state == ST_ARMED) && cut_req && (wire_to_cut != COL_NONE);
  assign cut_hit   = cut_valid && (cut_colour == wire_to_cut);
  assign cut_miss  = cut_valid && (cut_colour != wire_to_cut);

  assign defuse_now = cut_hit  && ((wires_q + 2'd1) == 2'(WIRES_NEEDED));
  assign strike_out = cut_miss && ((strikes_q + 2'd1) == 2'(MAX_STRIKES));

  // Tick and penalty are combined before clamping so a same-cycle pair
  // cannot wrap through zero.
  assign dec_amt        = {7'd0, tick} + (cut_miss ? 8'(PENALTY_SECS) : 8'd0);
  assign secs_live_next = 7'(sat_sub8({1'b0, secs_q}, dec_amt));
  assign secs_zero      = (secs_live_next == 7'd0);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE, ST_DEFUSED, ST_EXPLODED: begin
        if (start) next_state = ST_ARMED;
      end
      ST_ARMED: begin
        // A defusing cut beats the clock running out in the same cycle.
        if (defuse_now)                  next_state = ST_DEFUSED;
        else if (strike_out || secs_zero) next_state = ST_EXPLODED;
        else if (cut_miss)               next_state = ST_STRIKE;
      end
      ST_STRIKE: begin
        if (secs_zero)                         next_state = ST_EXPLODED;
        else if (strike_cnt_q == STRIKE_LAST)  next_state = ST_ARMED;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    pause_d    = (next_state != ST_ARMED);
    flash_d    = (next_state == ST_STRIKE);
    defused_d  = (next_state == ST_DEFUSED);
    exploded_d = (next_state == ST_EXPLODED);
  end

  always_comb begin
    secs_d       = secs_q;
    strikes_d    = strikes_q;
    wires_d      = wires_q;
    strike_cnt_d = '0;
    if (rearm) begin
      secs_d    = 7'(START_SECS);
      strikes_d = 2'd0;
      wires_d   = 2'd0;
    end else if (live) begin
      secs_d = secs_live_next;
      if (cut_hit)  wires_d   = wires_q + 2'd1;
      if (cut_miss) strikes_d = strikes_q + 2'd1;
      if (state == ST_STRIKE) strike_cnt_d = strike_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      secs_q       <= 7'(START_SECS);
      strikes_q    <= 2'd0;
      wires_q      <= 2'd0;
      strike_cnt_q <= '0;
      pause        <= 1'b1;
      flash        <= 1'b0;
      defused      <= 1'b0;
      exploded     <= 1'b0;
    end else begin
      secs_q       <= secs_d;
      strikes_q    <= strikes_d;
      wires_q      <= wires_d;
      strike_cnt_q <= strike_cnt_d;
      pause        <= pause_d;
      flash        <= flash_d;
      defused      <= defused_d;
      exploded     <= exploded_d;
    end
  end

  assign secs_left  = secs_q;
  assign strikes    = strikes_q;
  assign wires_done = wires_q;
  assign state_o    = state;

endmodule
